// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and byte-lane masks for the load/store sequencer.
package lsu_pkg;

  localparam logic [1:0] MEM_BYTE   = 2'b00;
  localparam logic [1:0] MEM_HALF   = 2'b01;
  localparam logic [1:0] MEM_WORD   = 2'b10;
  localparam logic       MEM_SIGNED = 1'b1;

  localparam logic [3:0] SIZE_MASK_BYTE = 4'h1;
  localparam logic [3:0] SIZE_MASK_HALF = 4'h3;
  localparam logic [3:0] SIZE_MASK_WORD = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_t;

  // Illegal size yields an empty mask so it can never request a split.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_mask = SIZE_MASK_BYTE;
      MEM_HALF: size_mask = SIZE_MASK_HALF;
      MEM_WORD: size_mask = SIZE_MASK_WORD;
      default:  size_mask = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_pack.sv
// Combinational lane packer: positions byte enables and store data across two words.
module lsu_store_pack (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic        split
);
  import lsu_pkg::*;

  // Any enable landing in the upper word means a second transaction.
  always_comb begin
    be8   = {4'h0, size_mask(size)} << off;
    wd64  = {32'h0, wdata} << {off, 3'b000};
    split = |be8[7:4];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory port.
// Misaligned half/word splitting is built only when LSU_MISALIGN_SPLIT_EN is defined.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_mem_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        dm_req,
  input  logic        dm_gnt,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);
  import lsu_pkg::*;

  localparam bit TO_EN = (TIMEOUT_CYC > 32'sd0);
  localparam int CW = (TIMEOUT_CYC > 32'sd1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYC - 32'sd1) : {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  lsu_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic        tmo, accept, err_n, bad_req;
  logic [1:0]  size_q, off_q;
  logic        sign_q, we_q;
  logic [31:0] addr_q, buf0, buf0_n;
  logic [7:0]  pk_be8;
  logic [63:0] pk_wd64, merged;
  logic        pk_split;
  logic [31:0] load_ext;
  logic        unused_bits;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0]  be_hi;
  logic [31:0] wd_hi, buf1, buf1_n;
  logic        split_q;
`endif

  lsu_store_pack u_pack (
    .size  (req_mem_op[1:0]),
    .off   (req_addr[1:0]),
    .wdata (req_wdata),
    .be8   (pk_be8),
    .wd64  (pk_wd64),
    .split (pk_split)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  assign bad_req     = (req_mem_op[1:0] == 2'b11);
  assign unused_bits = ^{req_mem_op[4:3], merged[63:32]};
`else
  assign bad_req     = (req_mem_op[1:0] == 2'b11) || pk_split;
  assign unused_bits = ^{req_mem_op[4:3], merged[63:32], pk_be8[7:4], pk_wd64[63:32]};
`endif

  assign accept = req_valid && req_ready;
  assign tmo    = TO_EN && (cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; err_n flags an erroring entry into RESP
  always_comb begin
    state_next = state;
    err_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && bad_req) begin
          state_next = ST_RESP;
          err_n      = 1'b1;
        end else if (accept) begin
          state_next = ST_ISSUE0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE0: begin
        if (dm_gnt)   state_next = ST_WAIT0;
        else if (tmo) begin state_next = ST_RESP; err_n = 1'b1; end
        else          state_next = ST_ISSUE0;
      end
      ST_WAIT0: begin
        if (dm_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_next = split_q ? ST_ISSUE1 : ST_RESP;
`else
          state_next = ST_RESP;
`endif
        end else if (tmo) begin
          state_next = ST_RESP;
          err_n      = 1'b1;
        end else begin
          state_next = ST_WAIT0;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_ISSUE1: begin
        if (dm_gnt)   state_next = ST_WAIT1;
        else if (tmo) begin state_next = ST_RESP; err_n = 1'b1; end
        else          state_next = ST_ISSUE1;
      end
      ST_WAIT1: begin
        if (dm_rvalid) state_next = ST_RESP;
        else if (tmo)  begin state_next = ST_RESP; err_n = 1'b1; end
        else           state_next = ST_WAIT1;
      end
`endif
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Phase timer restarts whenever the FSM changes state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= {CW{1'b0}};
    else if (state_next != state) cnt <= {CW{1'b0}};
    else if (state != ST_IDLE && state != ST_RESP) cnt <= cnt + CNT_ONE;
    else                          cnt <= {CW{1'b0}};
  end

  // Request capture at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      be_hi   <= 4'h0;
      wd_hi   <= 32'h0;
      split_q <= 1'b0;
`endif
    end else if (accept) begin
      size_q  <= req_mem_op[1:0];
      off_q   <= req_addr[1:0];
      sign_q  <= req_mem_op[2];
      we_q    <= req_we;
      addr_q  <= {req_addr[31:2], 2'b00};
`ifdef LSU_MISALIGN_SPLIT_EN
      be_hi   <= pk_be8[7:4];
      wd_hi   <= pk_wd64[63:32];
      split_q <= pk_split;
`endif
    end
  end

  // Read-word buffers and load alignment/extension
  always_comb begin
    if (state == ST_WAIT0 && dm_rvalid) buf0_n = dm_rdata;
    else                                buf0_n = buf0;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state == ST_WAIT1 && dm_rvalid) buf1_n = dm_rdata;
    else                                buf1_n = buf1;
    merged = {buf1_n, buf0_n} >> {off_q, 3'b000};
`else
    merged = {32'h0, buf0_n} >> {off_q, 3'b000};
`endif
    case (size_q)
      MEM_BYTE: load_ext = {{24{(sign_q == MEM_SIGNED) && merged[7]}}, merged[7:0]};
      MEM_HALF: load_ext = {{16{(sign_q == MEM_SIGNED) && merged[15]}}, merged[15:0]};
      MEM_WORD: load_ext = merged[31:0];
      default:  load_ext = 32'h0;
    endcase
  end

  // Buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0 <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      buf1 <= 32'h0;
`endif
    end else begin
      buf0 <= buf0_n;
`ifdef LSU_MISALIGN_SPLIT_EN
      buf1 <= buf1_n;
`endif
    end
  end

  // Registered outputs, loaded from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      dm_req     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      dm_we      <= 1'b0;
      dm_addr    <= 32'h0;
      dm_be      <= 4'h0;
      dm_wdata   <= 32'h0;
    end else begin
      req_ready  <= (state_next == ST_IDLE);
      busy       <= (state_next != ST_IDLE);
      dm_req     <= (state_next == ST_ISSUE0) || (state_next == ST_ISSUE1);
      resp_valid <= (state_next == ST_RESP);
      resp_err   <= (state_next == ST_RESP) && err_n;
      resp_rdata <= ((state_next == ST_RESP) && !err_n && !we_q) ? load_ext : 32'h0;
      if (state == ST_IDLE && state_next == ST_ISSUE0) begin
        dm_we    <= req_we;
        dm_addr  <= {req_addr[31:2], 2'b00};
        dm_be    <= pk_be8[3:0];
        dm_wdata <= pk_wd64[31:0];
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state == ST_WAIT0 && state_next == ST_ISSUE1) begin
        dm_addr  <= addr_q + 32'd4;
        dm_be    <= be_hi;
        dm_wdata <= wd_hi;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a response scoreboard; split cases follow LSU_MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [4:0]  req_mem_op = 5'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        dm_req, dm_we;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] dm_rdata = 32'h0;
  logic [3:0]  dm_be;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mem_op(req_mem_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .dm_req(dm_req), .dm_gnt(dm_gnt), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  typedef struct packed { logic err; logic [31:0] rdata; } resp_t;
  resp_t sb[$];

  int checks = 0, errors = 0;
  int nedge = 0, dmreq_cnt = 0, resp_cnt = 0;

  always @(negedge clk) begin
    nedge <= nedge + 1;
    if (dm_req)     dmreq_cnt <= dmreq_cnt + 1;
    if (resp_valid) resp_cnt  <= resp_cnt + 1;
  end

  localparam logic [4:0] OP_LW  = {2'b00, MEM_SIGNED, MEM_WORD};
  localparam logic [4:0] OP_LB  = {2'b00, MEM_SIGNED, MEM_BYTE};
  localparam logic [4:0] OP_LBU = {2'b00, ~MEM_SIGNED, MEM_BYTE};
  localparam logic [4:0] OP_LH  = {2'b00, MEM_SIGNED, MEM_HALF};
  localparam logic [4:0] OP_LHU = {2'b00, ~MEM_SIGNED, MEM_HALF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [4:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, output int t0);
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_mem_op = op; req_addr = addr; req_wdata = wdata;
    t0 = nedge;
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_mem_op = 5'h0; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic serve(input string tag, input int gnt_dly, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic exp_we, input logic [31:0] rdata);
    int n = 0;
    while (!dm_req && n < 20) begin @(negedge clk); n++; end
    check({tag, "_req"},   {31'h0, dm_req}, 32'h1);
    check({tag, "_addr"},  dm_addr, exp_addr);
    check({tag, "_be"},    {28'h0, dm_be}, {28'h0, exp_be});
    check({tag, "_wdata"}, dm_wdata, exp_wd);
    check({tag, "_we"},    {31'h0, dm_we}, {31'h0, exp_we});
    repeat (gnt_dly) @(negedge clk);
    check({tag, "_hold"},  {dm_addr[31:1], dm_req}, {exp_addr[31:1], 1'b1});
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = rdata;
    @(negedge clk);
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
  endtask

  task automatic get_resp(input string tag, output int t1);
    resp_t e;
    int n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    t1 = nedge;
    check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, "_sb"}, {31'h0, (sb.size() != 0)}, 32'h1);
    if (sb.size() != 0) e = sb.pop_front();
    else                e = '0;
    check({tag, "_err"},   {31'h0, resp_err}, {31'h0, e.err});
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    @(negedge clk);
    check({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    int t0, t1, n, d0, r0;
    resp_t drop;
    repeat (2) @(negedge clk);
    check("rst_dm_req",  {31'h0, dm_req}, 32'h0);
    check("rst_resp",    {30'h0, resp_valid, resp_err}, 32'h0);
    check("rst_busy",    {30'h0, busy, req_ready}, 32'h1);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_be_wd", {dm_be, dm_wdata[27:0]}, 32'h0);
    check("rst_rdata",   resp_rdata, 32'h0);
    rst_n = 1'b1;

    // Aligned word load with immediate grant: response three cycles after accept
    issue(1'b0, OP_LW, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, t0);
    check("lw_busy", {30'h0, busy, req_ready}, 32'h2);
    serve("lw", 0, 32'h100, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);
    get_resp("lw", t1);
    check("lw_lat", t1 - t0, 32'd3);

    issue(1'b0, OP_LB, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, t0);
    serve("lb", 0, 32'h100, 4'h8, 32'h0, 1'b0, 32'h80FFFFFF);
    get_resp("lb", t1);
    issue(1'b0, OP_LBU, 32'h103, 32'h0, 1'b0, 32'h00000080, t0);
    serve("lbu", 0, 32'h100, 4'h8, 32'h0, 1'b0, 32'h80FFFFFF);
    get_resp("lbu", t1);
    issue(1'b0, OP_LH, 32'h102, 32'h0, 1'b0, 32'hFFFFBEEF, t0);
    serve("lh", 1, 32'h100, 4'hC, 32'h0, 1'b0, 32'hBEEF1234);
    get_resp("lh", t1);
    issue(1'b0, OP_LHU, 32'h102, 32'h0, 1'b0, 32'h0000BEEF, t0);
    serve("lhu", 0, 32'h100, 4'hC, 32'h0, 1'b0, 32'hBEEF1234);
    get_resp("lhu", t1);
    // Upper op bits are ignored
    issue(1'b0, {2'b11, MEM_SIGNED, MEM_WORD}, 32'h104, 32'h0, 1'b0, 32'h0BADF00D, t0);
    serve("lw_hi", 0, 32'h104, 4'hF, 32'h0, 1'b0, 32'h0BADF00D);
    get_resp("lw_hi", t1);

    issue(1'b1, {2'b00, 1'b0, MEM_WORD}, 32'h300, 32'h12345678, 1'b0, 32'h0, t0);
    serve("sw", 2, 32'h300, 4'hF, 32'h12345678, 1'b1, 32'hFFFFFFFF);
    get_resp("sw", t1);
    issue(1'b1, {2'b00, 1'b0, MEM_BYTE}, 32'h301, 32'h000000A5, 1'b0, 32'h0, t0);
    serve("sb", 0, 32'h300, 4'h2, 32'h0000A500, 1'b1, 32'h0);
    get_resp("sb", t1);

`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b1, {2'b00, 1'b0, MEM_HALF}, 32'h203, 32'h0000ABCD, 1'b0, 32'h0, t0);
    serve("sh0", 0, 32'h200, 4'h8, 32'hCD000000, 1'b1, 32'h0);
    serve("sh1", 0, 32'h204, 4'h1, 32'h000000AB, 1'b1, 32'h0);
    get_resp("sh", t1);
    check("sh_lat", t1 - t0, 32'd5);
    issue(1'b0, OP_LW, 32'hFFFFFFFE, 32'h0, 1'b0, 32'h11223344, t0);
    serve("lwx0", 0, 32'hFFFFFFFC, 4'hC, 32'h0, 1'b0, 32'h33445566);
    serve("lwx1", 0, 32'h00000000, 4'h3, 32'h0, 1'b0, 32'h77881122);
    get_resp("lwx", t1);
`else
    d0 = dmreq_cnt;
    issue(1'b1, {2'b00, 1'b0, MEM_HALF}, 32'h203, 32'h0000ABCD, 1'b1, 32'h0, t0);
    get_resp("sh_nosplit", t1);
    check("sh_nosplit_lat", t1 - t0, 32'd1);
    issue(1'b0, OP_LW, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h0, t0);
    get_resp("lwx_nosplit", t1);
    check("nosplit_no_dm", dmreq_cnt - d0, 32'd0);
`endif

    // Grant never arrives: dm_req held exactly TIMEOUT_CYC cycles
    issue(1'b0, OP_LW, 32'h400, 32'h0, 1'b1, 32'h0, t0);
    n = 0;
    while (dm_req && n < 20) begin n++; @(negedge clk); end
    check("tmo_req_cycles", n, 32'd4);
    get_resp("tmo", t1);

    d0 = dmreq_cnt;
    issue(1'b0, 5'b00011, 32'h100, 32'h0, 1'b1, 32'h0, t0);
    get_resp("illegal", t1);
    check("illegal_lat", t1 - t0, 32'd1);
    check("illegal_no_dm", dmreq_cnt - d0, 32'd0);

    // Reset while waiting for read data aborts silently
    issue(1'b0, OP_LW, 32'h500, 32'h0, 1'b0, 32'h0, t0);
    check("rst_mid_req", {31'h0, dm_req}, 32'h1);
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    check("rst_mid_wait", {30'h0, busy, dm_req}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dm_req", {31'h0, dm_req}, 32'h0);
    check("rst_mid_busy", {30'h0, busy, req_ready}, 32'h1);
    if (sb.size() != 0) drop = sb.pop_back();
    else                drop = '0;
    @(negedge clk);
    rst_n = 1'b1;
    r0 = resp_cnt;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("stale_rvalid_no_resp", resp_cnt - r0, 32'd0);

    issue(1'b0, OP_LW, 32'h600, 32'h0, 1'b0, 32'h01020304, t0);
    serve("post_rst", 0, 32'h600, 4'hF, 32'h0, 1'b0, 32'h01020304);
    get_resp("post_rst", t1);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
